// File: rtl/fx_sched_pkg.sv
// Shared types and constants for the FX edge-update scheduler.
// Default field widths match fx_edge_scheduler's PRED_W / WEIGHT_W defaults.
package fx_sched_pkg;

    localparam int PKG_PRED_W   = 4;
    localparam int PKG_WEIGHT_W = 32;

    localparam logic [2:0] ADDR_PAIR   = 3'd0;
    localparam logic [2:0] ADDR_WEIGHT = 3'd1;
    localparam logic [2:0] ADDR_CTRL   = 3'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        START = 2'd2,
        RUN   = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic [PKG_PRED_W-1:0]   src;
        logic [PKG_PRED_W-1:0]   dst;
        logic [PKG_WEIGHT_W-1:0] weight;
    } edge_upd_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/fx_edge_fifo.sv
// Synchronous FIFO of edge updates; head entry read straight from the storage flops.
module fx_edge_fifo
    import fx_sched_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  edge_upd_t                din,
    output edge_upd_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    edge_upd_t     mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == (AW+1)'(0));
    assign count     = count_r;
    assign head      = mem_r[rd_ptr_r];
    assign do_pop_s  = pop && !empty;
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign do_push_s = push && (!full || do_pop_s);

    // storage, pointers and occupancy; storage cleared so outputs read zero out of reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{default: 1'b0};
            end
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fx_edge_scheduler.sv
// Queues bus edge-weight updates and applies them to the Container between passes.
// Optional FX_SCHED_DROP_COUNT_EN adds a saturating drop_count output.
module fx_edge_scheduler
    import fx_sched_pkg::*;
#(
    parameter int PRED_W   = PKG_PRED_W,
    parameter int WEIGHT_W = PKG_WEIGHT_W,
    parameter int DEPTH    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                chipselect,
    input  logic                write,
    input  logic [2:0]          address,
    input  logic [WEIGHT_W-1:0] writedata,
    output logic                upd_valid,
    input  logic                upd_ready,
    output logic [PRED_W-1:0]   upd_src,
    output logic [PRED_W-1:0]   upd_dst,
    output logic [WEIGHT_W-1:0] upd_weight,
    output logic                ctr_reset,
    input  logic                ctr_done,
    output logic                busy,
    output logic                overflow
`ifdef FX_SCHED_DROP_COUNT_EN
    ,
    output logic [15:0]         drop_count
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    sched_state_t      state_r;
    sched_state_t      next_state_s;
    logic [PRED_W-1:0] stage_src_r;
    logic [PRED_W-1:0] stage_dst_r;
    logic              run_pending_r;
    logic              overflow_r;
    logic              ctr_reset_r;
    logic [CW-1:0]     remaining_r;
    logic              bus_wr_s;
    logic              push_s;
    logic              ctrl_wr_s;
    logic              pop_s;
    logic              drop_s;
    logic              leave_idle_s;
    edge_upd_t         fifo_din_s;
    edge_upd_t         fifo_head_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CW-1:0]     fifo_count_s;

    assign bus_wr_s     = write && chipselect;
    assign push_s       = bus_wr_s && (address == ADDR_WEIGHT);
    assign ctrl_wr_s    = bus_wr_s && (address == ADDR_CTRL);
    assign upd_valid    = (state_r == APPLY) && (remaining_r != CW'(0));
    assign pop_s        = upd_valid && upd_ready;
    assign drop_s       = push_s && fifo_full_s && !pop_s;
    assign leave_idle_s = (state_r == IDLE) && (next_state_s == APPLY);
    assign fifo_din_s   = '{src: stage_src_r, dst: stage_dst_r, weight: writedata};

    fx_edge_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (fifo_din_s),
        .head  (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign upd_src    = fifo_head_s.src;
    assign upd_dst    = fifo_head_s.dst;
    assign upd_weight = fifo_head_s.weight;
    assign ctr_reset  = ctr_reset_r;
    assign busy       = (state_r != IDLE);
    assign overflow   = overflow_r;

    // pass sequencing: the final accepted update moves straight on to START
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s || run_pending_r) next_state_s = APPLY;
                else                                next_state_s = IDLE;
            end
            APPLY: begin
                if ((remaining_r == CW'(0)) || (pop_s && (remaining_r == CW'(1))))
                    next_state_s = START;
                else
                    next_state_s = APPLY;
            end
            START:   next_state_s = RUN;
            RUN: begin
                if (ctr_done) next_state_s = IDLE;
                else          next_state_s = RUN;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // state register; Container is held in reset while we are
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            ctr_reset_r <= 1'b1;
        end else begin
            state_r     <= next_state_s;
            ctr_reset_r <= (next_state_s == START);
        end
    end

    // updates owed this pass: snapshot on leaving IDLE so later pushes wait a pass
    always_ff @(posedge clk) begin
        if (!reset) begin
            remaining_r <= CW'(0);
        end else if (leave_idle_s) begin
            remaining_r <= fifo_count_s;
        end else if (pop_s) begin
            remaining_r <= remaining_r - CW'(1);
        end else begin
            remaining_r <= remaining_r;
        end
    end

    // bus-side registers: vertex staging, run request, sticky overflow
    always_ff @(posedge clk) begin
        if (!reset) begin
            stage_src_r   <= {PRED_W{1'b0}};
            stage_dst_r   <= {PRED_W{1'b0}};
            run_pending_r <= 1'b0;
            overflow_r    <= 1'b0;
        end else begin
            if (bus_wr_s && (address == ADDR_PAIR)) begin
                stage_src_r <= writedata[2*PRED_W-1:PRED_W];
                stage_dst_r <= writedata[PRED_W-1:0];
            end else begin
                stage_src_r <= stage_src_r;
                stage_dst_r <= stage_dst_r;
            end
            if (leave_idle_s)                    run_pending_r <= 1'b0;
            else if (ctrl_wr_s && writedata[0])  run_pending_r <= 1'b1;
            else                                 run_pending_r <= run_pending_r;
            if (drop_s)                          overflow_r <= 1'b1;
            else if (ctrl_wr_s && writedata[1])  overflow_r <= 1'b0;
            else                                 overflow_r <= overflow_r;
        end
    end

`ifdef FX_SCHED_DROP_COUNT_EN
    logic [15:0] drop_count_r;

    assign drop_count = drop_count_r;

    // saturating tally of dropped pushes, cleared together with overflow
    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_count_r <= 16'd0;
        end else if (drop_s) begin
            drop_count_r <= sat_inc16(drop_count_r);
        end else if (ctrl_wr_s && writedata[1]) begin
            drop_count_r <= 16'd0;
        end else begin
            drop_count_r <= drop_count_r;
        end
    end
`else
    // without the counter, the sticky overflow flag is the only drop indication
`endif

endmodule

// File: tb/tb_fx_edge_scheduler.sv
// Self-checking bench for fx_edge_scheduler: directed scenarios then random traffic,
// every cycle compared against a queue-based model of the scheduling rules.
module tb_fx_edge_scheduler;

    localparam int DEPTH   = 8;
    localparam int P_IDLE  = 0;
    localparam int P_APPLY = 1;
    localparam int P_START = 2;
    localparam int P_RUN   = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        chipselect = 1'b0;
    logic        write = 1'b0;
    logic [2:0]  address = 3'd0;
    logic [31:0] writedata = 32'd0;
    logic        upd_ready = 1'b0;
    logic        ctr_done = 1'b0;
    logic        upd_valid;
    logic [3:0]  upd_src;
    logic [3:0]  upd_dst;
    logic [31:0] upd_weight;
    logic        ctr_reset;
    logic        busy;
    logic        overflow;
`ifdef FX_SCHED_DROP_COUNT_EN
    logic [15:0] drop_count;
`endif

    always #5 clk = ~clk;

    fx_edge_scheduler #(.PRED_W(4), .WEIGHT_W(32), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .address    (address),
        .writedata  (writedata),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_src    (upd_src),
        .upd_dst    (upd_dst),
        .upd_weight (upd_weight),
        .ctr_reset  (ctr_reset),
        .ctr_done   (ctr_done),
        .busy       (busy),
        .overflow   (overflow)
`ifdef FX_SCHED_DROP_COUNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    typedef struct {
        logic [3:0]  s;
        logic [3:0]  d;
        logic [31:0] w;
    } ent_t;

    ent_t        m_q[$];
    int          m_phase = P_IDLE;
    int          m_rem = 0;
    bit          m_pend = 1'b0;
    bit          m_ovf = 1'b0;
    bit          m_ctr = 1'b1;
    bit          m_rst = 1'b1;
    int          m_drop = 0;
    logic [3:0]  m_ss = 4'd0;
    logic [3:0]  m_sd = 4'd0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          pulse_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one clock of the scheduling rules to the inputs present at the edge.
    task automatic model_step();
        bit   valid, pop, push, ctrl, go;
        int   qn;
        ent_t e;
        if (!reset) begin
            m_q.delete();
            m_phase = P_IDLE; m_rem = 0; m_pend = 1'b0; m_ovf = 1'b0; m_drop = 0;
            m_ss = 4'd0; m_sd = 4'd0; m_ctr = 1'b1; m_rst = 1'b1;
            return;
        end
        m_rst = 1'b0;
        qn    = m_q.size();
        valid = (m_phase == P_APPLY) && (m_rem != 0);
        pop   = valid && upd_ready;
        push  = chipselect && write && (address == 3'd1);
        ctrl  = chipselect && write && (address == 3'd2);
        go    = 1'b0;
        case (m_phase)
            P_IDLE:  if (qn != 0 || m_pend) begin m_phase = P_APPLY; m_rem = qn; go = 1'b1; end
            P_APPLY: begin
                if (pop) m_rem--;
                if (m_rem == 0) m_phase = P_START;
            end
            P_START: m_phase = P_RUN;
            default: if (ctr_done) m_phase = P_IDLE;
        endcase
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (qn == DEPTH && !pop) begin
                m_ovf = 1'b1;
                if (m_drop < 65535) m_drop++;
            end else begin
                e.s = m_ss; e.d = m_sd; e.w = writedata;
                m_q.push_back(e);
            end
        end
        if (go) m_pend = 1'b0;
        else if (ctrl && writedata[0]) m_pend = 1'b1;
        if (ctrl && writedata[1]) begin m_ovf = 1'b0; m_drop = 0; end
        if (chipselect && write && address == 3'd0) begin
            m_ss = writedata[7:4];
            m_sd = writedata[3:0];
        end
        m_ctr = (m_phase == P_START);
    endtask

    task automatic compare_all();
        bit exp_valid;
        exp_valid = (m_phase == P_APPLY) && (m_rem != 0);
        chk("busy", 32'(busy), 32'(m_phase != P_IDLE));
        chk("upd_valid", 32'(upd_valid), 32'(exp_valid));
        chk("ctr_reset", 32'(ctr_reset), 32'(m_ctr));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (exp_valid) begin
            chk("upd_src", 32'(upd_src), 32'(m_q[0].s));
            chk("upd_dst", 32'(upd_dst), 32'(m_q[0].d));
            chk("upd_weight", upd_weight, m_q[0].w);
        end
        if (m_rst) begin
            chk("rst_src", 32'(upd_src), 32'd0);
            chk("rst_dst", 32'(upd_dst), 32'd0);
            chk("rst_weight", upd_weight, 32'd0);
        end
`ifdef FX_SCHED_DROP_COUNT_EN
        chk("drop_count", 32'(drop_count), 32'(m_drop));
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        if (reset && ctr_reset) pulse_cnt++;
    endtask

    task automatic bus(input logic [2:0] a, input logic [31:0] wd);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = wd;
        cyc();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic push_upd(input logic [3:0] s, input logic [3:0] d, input logic [31:0] w);
        bus(3'd0, {24'd0, s, d});
        bus(3'd1, w);
    endtask

    task automatic timeout(input string tag);
        n_cmp++;
        n_bad++;
        $error("FAIL %s observed=timeout expected=completion", tag);
    endtask

    // Run until the model is idle with nothing queued, pulsing ctr_done in RUN.
    task automatic drain(input string tag, input bit toggle, input int budget);
        int n;
        n = 0;
        while (!(m_phase == P_IDLE && m_q.size() == 0 && !m_pend)) begin
            if (n >= budget) begin timeout(tag); break; end
            if (toggle) upd_ready = ~upd_ready;
            ctr_done = (m_phase == P_RUN);
            cyc();
            n++;
        end
        ctr_done = 1'b0;
        cyc();
    endtask

    task automatic wait_phase(input int ph, input string tag, input int budget);
        int n;
        n = 0;
        while (m_phase != ph) begin
            if (n >= budget) begin timeout(tag); break; end
            cyc();
            n++;
        end
    endtask

    initial begin
        // reset state
        reset = 1'b0;
        repeat (2) cyc();
        reset = 1'b1;
        cyc();

        // 1: single update
        upd_ready = 1'b1;
        pulse_cnt = 0;
        push_upd(4'd3, 4'd5, 32'h0000_1234);
        drain("single_pass", 1'b0, 50);
        chk("t1_pulses", 32'(pulse_cnt), 32'd1);

        // 2: overflow on the ninth push, then clear
        upd_ready = 1'b0;
        bus(3'd0, 32'h0000_0012);
        for (int i = 0; i < DEPTH + 1; i++) bus(3'd1, 32'hA000_0000 + 32'(i));
        chk("t2_overflow", 32'(overflow), 32'd1);
`ifdef FX_SCHED_DROP_COUNT_EN
        chk("t2_drop_count", 32'(drop_count), 32'd1);
`endif
        bus(3'd2, 32'd2);
        chk("t2_cleared", 32'(overflow), 32'd0);
        upd_ready = 1'b1;
        drain("overflow_drain", 1'b0, 300);

        // 3: push during RUN yields a second pass
        pulse_cnt = 0;
        push_upd(4'd1, 4'd7, 32'hDEAD_BEEF);
        wait_phase(P_RUN, "reach_run", 50);
        push_upd(4'd2, 4'd6, 32'hFFFF_FF00);
        drain("two_pass", 1'b0, 100);
        chk("t3_pulses", 32'(pulse_cnt), 32'd2);

        // 4: ready toggling over four updates
        upd_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_upd(4'(i + 8), 4'(15 - i), 32'h5555_0000 + 32'(i));
        drain("toggle_ready", 1'b1, 200);

        // 5: empty pass on request
        upd_ready = 1'b1;
        bus(3'd2, 32'd1);
        drain("empty_pass", 1'b0, 50);

        // 6: reset in the middle of APPLY
        upd_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_upd(4'(i), 4'(i + 1), 32'h7000_0000 + 32'(i));
        wait_phase(P_APPLY, "reach_apply", 20);
        reset = 1'b0;
        cyc();
        chk("t6_ctr_reset", 32'(ctr_reset), 32'd1);
        chk("t6_valid", 32'(upd_valid), 32'd0);
        reset = 1'b1;
        upd_ready = 1'b1;
        repeat (6) cyc();

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            chipselect = ($urandom_range(0, 3) != 0);
            write      = ($urandom_range(0, 2) != 0);
            address    = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            writedata  = $urandom;
            if (address == 3'd2) writedata[1] = ($urandom_range(0, 7) == 0);
            upd_ready  = ($urandom_range(0, 2) != 0);
            ctr_done   = ($urandom_range(0, 4) == 0);
            reset      = ($urandom_range(0, 299) != 0);
            cyc();
        end
        chipselect = 1'b0; write = 1'b0; reset = 1'b1; upd_ready = 1'b1;
        drain("random_drain", 1'b0, 400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
